exu_result_queue: RTL

//  Parametrised successor to the single-result execution stage. Executes 1-cycle integer ops
//  (ADD/SUB/logic/shift/LI) at configurable XLEN and merges them, in arrival order, with
//  FPU completions into a DEPTH-entry result FIFO. Drains to writeback via valid/ready.

---
 rtl/exu_result_queue.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/exu_result_queue.sv
// Execution-stage result queue: 1-cycle integer ALU plus FPU completions merged in arrival order
// into a registered DEPTH-entry FIFO that drains to writeback via valid/ready.
module exu_result_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned FLEN  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [2:0]               issue_op,
    input  logic [XLEN-1:0]          issue_rs1,
    input  logic [XLEN-1:0]          issue_rs2,
    input  logic [TAG_W-1:0]         issue_tag,
    input  logic                     fpu_busy,
    input  logic                     fpu_complete,
    input  logic [FLEN-1:0]          fpu_result,
    input  logic [4:0]               fpu_flags,
    input  logic [TAG_W-1:0]         fpu_tag,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [XLEN-1:0]          wb_data,
    output logic [TAG_W-1:0]         wb_tag,
    output logic                     wb_is_fp,
    output logic [4:0]               wb_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0]  data_mem  [DEPTH];
    logic [TAG_W-1:0] tag_mem   [DEPTH];
    logic             fp_mem    [DEPTH];
    logic [4:0]       flags_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic [XLEN-1:0]  alu_res, fp_boxed, wr_data;
    logic [TAG_W-1:0] wr_tag;
    logic [4:0]       wr_flags;
    logic             wr_fp, wr_en, int_wr, fpu_wr, deq, full;
    logic [CW:0]      need;

    always_comb begin
        alu_res = '0;
        case (issue_op)
            3'b000:  alu_res = issue_rs1 + issue_rs2;
            3'b001:  alu_res = issue_rs1 - issue_rs2;
            3'b010:  alu_res = issue_rs1 & issue_rs2;
            3'b011:  alu_res = issue_rs1 | issue_rs2;
            3'b100:  alu_res = issue_rs1 ^ issue_rs2;
            3'b101:  alu_res = issue_rs1 << issue_rs2[SW-1:0];
            3'b110:  alu_res = issue_rs1 >> issue_rs2[SW-1:0];
            default: alu_res = issue_rs1;
        endcase
    end

    // NaN-boxing; written this way so FLEN == XLEN needs no zero-width replication.
    always_comb begin
        fp_boxed = '1;
        fp_boxed[FLEN-1:0] = fpu_result;
    end

    assign full        = (count_q == CW'(DEPTH));
    assign deq         = wb_valid & wb_ready;
    assign need        = {1'b0, count_q} + {{CW{1'b0}}, fpu_busy};
    assign issue_ready = !flush && !fpu_complete && (need < (CW + 1)'(DEPTH));
    assign int_wr      = issue_valid & issue_ready;
    // A full queue still takes an FPU result if the head leaves in the same cycle.
    assign fpu_wr      = fpu_complete & !flush & (!full | deq);
    assign wr_en       = int_wr | fpu_wr;

    always_comb begin
        wr_data  = alu_res;
        wr_tag   = issue_tag;
        wr_fp    = 1'b0;
        wr_flags = 5'b0;
        if (fpu_complete) begin
            wr_data  = fp_boxed;
            wr_tag   = fpu_tag;
            wr_fp    = 1'b1;
            wr_flags = fpu_flags;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (fpu_complete & !flush & full & !deq);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq)   rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en && !deq)      count_d = count_q + 1'b1;
            else if (!wr_en && deq) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_q]  <= wr_data;
            tag_mem[wr_ptr_q]   <= wr_tag;
            fp_mem[wr_ptr_q]    <= wr_fp;
            flags_mem[wr_ptr_q] <= wr_flags;
        end
    end

    always_comb begin
        wb_valid = (count_q != '0);
        wb_data  = '0;
        wb_tag   = '0;
        wb_is_fp = 1'b0;
        wb_flags = 5'b0;
        if (wb_valid) begin
            wb_data  = data_mem[rd_ptr_q];
            wb_tag   = tag_mem[rd_ptr_q];
            wb_is_fp = fp_mem[rd_ptr_q];
            wb_flags = flags_mem[rd_ptr_q];
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule
